cp0_exc_ctrl: RTL and testbench



---
 rtl/cp0_exc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET sequencer on the consumer side of CP0: it takes a snapshot of the
// trigger, writes EPC/Cause/Status through the single CP0 write port, then redirects fetch.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          CP0_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_pc,
  input  logic                  mem_in_delay_slot,
  input  logic                  mem_exc_req,
  input  logic [4:0]            mem_exc_code,
  input  logic                  mem_eret,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  output logic                  cp0_we,
  output logic [CP0_ADDR_W-1:0] cp0_waddr,
  output logic [31:0]           cp0_wdata,
  output logic                  busy,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_EPC    = 3'd1;
  localparam logic [2:0] S_W_CAUSE  = 3'd2;
  localparam logic [2:0] S_W_STATUS = 3'd3;
  localparam logic [2:0] S_E_STATUS = 3'd4;
  localparam logic [2:0] S_REDIRECT = 3'd5;

  localparam logic [CP0_ADDR_W-1:0] ADDR_STATUS = CP0_ADDR_W'(12);
  localparam logic [CP0_ADDR_W-1:0] ADDR_CAUSE  = CP0_ADDR_W'(13);
  localparam logic [CP0_ADDR_W-1:0] ADDR_EPC    = CP0_ADDR_W'(14);

  logic [2:0]            state_reg, state_next;
  logic [31:0]           snap_pc_reg, snap_pc_next;
  logic                  snap_bd_reg, snap_bd_next;
  logic [4:0]            snap_code_reg, snap_code_next;
  logic                  snap_eret_reg, snap_eret_next;
  logic [31:0]           snap_status_reg, snap_status_next;
  logic [31:0]           snap_cause_reg, snap_cause_next;
  logic [31:0]           snap_epc_reg, snap_epc_next;

  logic                  we_reg, we_next;
  logic [CP0_ADDR_W-1:0] waddr_reg, waddr_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic                  busy_reg, busy_next;
  logic                  redirect_valid_reg, redirect_valid_next;
  logic [31:0]           redirect_pc_reg, redirect_pc_next;

  logic [7:0] int_pending;
  logic       int_take;
  logic       exc_take;
  logic       eret_take;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_int_line
      assign int_pending[gi] = cp0_cause[8+gi] & cp0_status[8+gi];
    end
  endgenerate

  // EXL (Status[1]) masks interrupts but never synchronous exceptions.
  assign int_take  = cp0_status[0] & ~cp0_status[1] & (|int_pending);
  assign exc_take  = int_take | mem_exc_req;
  assign eret_take = ~exc_take & mem_eret;

  always_comb begin
    state_next       = state_reg;
    snap_pc_next     = snap_pc_reg;
    snap_bd_next     = snap_bd_reg;
    snap_code_next   = snap_code_reg;
    snap_eret_next   = snap_eret_reg;
    snap_status_next = snap_status_reg;
    snap_cause_next  = snap_cause_reg;
    snap_epc_next    = snap_epc_reg;
    case (state_reg)
      S_IDLE: begin
        if (mem_valid && (exc_take || eret_take)) begin
          snap_pc_next     = mem_pc;
          snap_bd_next     = mem_in_delay_slot;
          snap_code_next   = int_take ? 5'd0 : mem_exc_code;
          snap_eret_next   = eret_take;
          snap_status_next = cp0_status;
          snap_cause_next  = cp0_cause;
          snap_epc_next    = cp0_epc;
          state_next       = exc_take ? S_W_EPC : S_E_STATUS;
        end
      end
      S_W_EPC:    state_next = S_W_CAUSE;
      S_W_CAUSE:  state_next = S_W_STATUS;
      S_W_STATUS: state_next = S_REDIRECT;
      S_E_STATUS: state_next = S_REDIRECT;
      S_REDIRECT: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they leave straight from flops.
  always_comb begin
    we_next             = 1'b0;
    waddr_next          = '0;
    wdata_next          = 32'd0;
    redirect_valid_next = 1'b0;
    redirect_pc_next    = redirect_pc_reg;
    busy_next           = (state_next != S_IDLE);
    case (state_next)
      S_W_EPC: begin
        we_next    = 1'b1;
        waddr_next = ADDR_EPC;
        wdata_next = snap_bd_next ? (snap_pc_next - 32'd4) : snap_pc_next;
      end
      S_W_CAUSE: begin
        we_next    = 1'b1;
        waddr_next = ADDR_CAUSE;
        wdata_next = {snap_bd_next, snap_cause_next[30:7], snap_code_next, snap_cause_next[1:0]};
      end
      S_W_STATUS: begin
        we_next    = 1'b1;
        waddr_next = ADDR_STATUS;
        wdata_next = snap_status_next | 32'h0000_0002;
      end
      S_E_STATUS: begin
        we_next    = 1'b1;
        waddr_next = ADDR_STATUS;
        wdata_next = snap_status_next & ~32'h0000_0002;
      end
      S_REDIRECT: begin
        redirect_valid_next = 1'b1;
        redirect_pc_next    = snap_eret_next ? snap_epc_next : EXC_VECTOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= S_IDLE;
      snap_pc_reg        <= 32'd0;
      snap_bd_reg        <= 1'b0;
      snap_code_reg      <= 5'd0;
      snap_eret_reg      <= 1'b0;
      snap_status_reg    <= 32'd0;
      snap_cause_reg     <= 32'd0;
      snap_epc_reg       <= 32'd0;
      we_reg             <= 1'b0;
      waddr_reg          <= '0;
      wdata_reg          <= 32'd0;
      busy_reg           <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= 32'd0;
    end else begin
      state_reg          <= state_next;
      snap_pc_reg        <= snap_pc_next;
      snap_bd_reg        <= snap_bd_next;
      snap_code_reg      <= snap_code_next;
      snap_eret_reg      <= snap_eret_next;
      snap_status_reg    <= snap_status_next;
      snap_cause_reg     <= snap_cause_next;
      snap_epc_reg       <= snap_epc_next;
      we_reg             <= we_next;
      waddr_reg          <= waddr_next;
      wdata_reg          <= wdata_next;
      busy_reg           <= busy_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
    end
  end

  assign cp0_we         = we_reg;
  assign cp0_waddr      = waddr_reg;
  assign cp0_wdata      = wdata_reg;
  assign busy           = busy_reg;
  assign flush          = busy_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Testbench for cp0_exc_ctrl: a queue-based reference model is compared every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_pc = 32'd0;
  logic        mem_in_delay_slot = 1'b0;
  logic        mem_exc_req = 1'b0;
  logic [4:0]  mem_exc_code = 5'd0;
  logic        mem_eret = 1'b0;
  logic [31:0] cp0_status = 32'd0;
  logic [31:0] cp0_cause = 32'd0;
  logic [31:0] cp0_epc = 32'd0;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        busy;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exc_ctrl #(.EXC_VECTOR(32'hBFC00380), .CP0_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_in_delay_slot(mem_in_delay_slot), .mem_exc_req(mem_exc_req),
    .mem_exc_code(mem_exc_code), .mem_eret(mem_eret), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .busy(busy), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected output record per cycle after each clock edge.
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
  } exp_t;

  exp_t        plan[$];
  exp_t        cur;
  logic [31:0] last_rpc;

  function automatic exp_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic rv, input logic [31:0] rpc, input logic b);
    exp_t e;
    e.we = we; e.waddr = a; e.wdata = d; e.rv = rv; e.rpc = rpc; e.busy = b;
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      plan.delete();
      cur      <= '0;
      last_rpc <= 32'd0;
    end else begin
      exp_t        nxt;
      logic        irq;
      logic [4:0]  code;
      logic [31:0] prev_rpc;
      prev_rpc = last_rpc;
      if (plan.size() == 0 && !cur.busy && mem_valid) begin
        irq  = cp0_status[0] && !cp0_status[1] && ((cp0_cause[15:8] & cp0_status[15:8]) != 8'd0);
        code = irq ? 5'd0 : mem_exc_code;
        if (irq || mem_exc_req) begin
          plan.push_back(mk(1'b1, 5'd14, mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc, 1'b0, prev_rpc, 1'b1));
          plan.push_back(mk(1'b1, 5'd13,
                            (cp0_cause & 32'h7FFF_FF83) | ({31'd0, mem_in_delay_slot} << 31) | ({27'd0, code} << 2),
                            1'b0, prev_rpc, 1'b1));
          plan.push_back(mk(1'b1, 5'd12, cp0_status | 32'd2, 1'b0, prev_rpc, 1'b1));
          plan.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 32'hBFC00380, 1'b1));
        end else if (mem_eret) begin
          plan.push_back(mk(1'b1, 5'd12, cp0_status & ~32'd2, 1'b0, prev_rpc, 1'b1));
          plan.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, cp0_epc, 1'b1));
        end
      end
      if (plan.size() > 0) nxt = plan.pop_front();
      else nxt = mk(1'b0, 5'd0, 32'd0, 1'b0, prev_rpc, 1'b0);
      cur <= nxt;
      if (nxt.rv) last_rpc <= nxt.rpc;
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, cur.busy});
    check("flush", {31'd0, flush}, {31'd0, cur.busy});
    check("we", {31'd0, cp0_we}, {31'd0, cur.we});
    if (cur.we) begin
      check("waddr", {27'd0, cp0_waddr}, {27'd0, cur.waddr});
      check("wdata", cp0_wdata, cur.wdata);
    end
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, cur.rv});
    check("redirect_pc", redirect_pc, cur.rpc);
    if (cp0_we) $display("t=%0t cp0 write addr=%0d data=%h", $time, cp0_waddr, cp0_wdata);
    if (redirect_valid) $display("t=%0t redirect pc=%h", $time, redirect_pc);
  end

  // Presents one instruction for exactly one accepting edge, then drops the triggers.
  task automatic fire(input logic v, input logic [31:0] pc, input logic bd, input logic exc,
                      input logic [4:0] code, input logic eret, input logic [31:0] st,
                      input logic [31:0] ca, input logic [31:0] ep);
    @(posedge clk); #1;
    mem_valid = v; mem_pc = pc; mem_in_delay_slot = bd; mem_exc_req = exc;
    mem_exc_code = code; mem_eret = eret; cp0_status = st; cp0_cause = ca; cp0_epc = ep;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_exc_req = 1'b0; mem_eret = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    idle(3);
    rst = 1'b1;
    idle(2);

    // Ov exception
    fire(1'b1, 32'hBFC00100, 1'b0, 1'b1, 5'd12, 1'b0, 32'h1, 32'h0, 32'h0);
    next_cycle(); check("ov_epc_addr", {27'd0, cp0_waddr}, 32'd14);
                  check("ov_epc_data", cp0_wdata, 32'hBFC00100);
    next_cycle(); check("ov_cause_data", cp0_wdata, 32'h0000_0030);
    next_cycle(); check("ov_status_data", cp0_wdata, 32'h0000_0003);
    next_cycle(); check("ov_redirect_valid", {31'd0, redirect_valid}, 32'd1);
                  check("ov_redirect_pc", redirect_pc, 32'hBFC00380);
    idle(3);
    check("ov_hold_pc", redirect_pc, 32'hBFC00380);

    // Delay-slot Sys
    fire(1'b1, 32'h80000010, 1'b1, 1'b1, 5'd8, 1'b0, 32'h1, 32'h0, 32'h0);
    next_cycle(); check("bd_epc_data", cp0_wdata, 32'h8000000C);
    next_cycle(); check("bd_cause_data", cp0_wdata, 32'h8000_0020);
    idle(5);

    // Interrupt beats a simultaneous RI
    fire(1'b1, 32'h80000200, 1'b0, 1'b1, 5'd10, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0);
    next_cycle(); check("irq_epc_data", cp0_wdata, 32'h80000200);
    next_cycle(); check("irq_cause_data", cp0_wdata, 32'h0000_0400);
    next_cycle(); check("irq_status_data", cp0_wdata, 32'h0000_0403);
    idle(4);

    // EXL masks the interrupt
    fire(1'b1, 32'h80000200, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0);
    next_cycle(); check("exl_mask_busy", {31'd0, busy}, 32'd0);
    next_cycle(); check("exl_mask_busy2", {31'd0, busy}, 32'd0);

    // EXL still lets a synchronous exception through
    fire(1'b1, 32'h80000300, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0000_0403, 32'h0, 32'h0);
    next_cycle(); check("exl_exc_busy", {31'd0, busy}, 32'd1);
    idle(5);

    // mem_valid=0 blocks a pending interrupt
    fire(1'b0, 32'h80000400, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0);
    next_cycle(); check("novalid_busy", {31'd0, busy}, 32'd0);

    // ERET
    fire(1'b1, 32'h80000500, 1'b0, 1'b0, 5'd0, 1'b1, 32'h3, 32'h0, 32'h80001234);
    next_cycle(); check("eret_status_addr", {27'd0, cp0_waddr}, 32'd12);
                  check("eret_status_data", cp0_wdata, 32'h0000_0001);
    next_cycle(); check("eret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
                  check("eret_redirect_pc", redirect_pc, 32'h80001234);
    idle(3);

    // Exception beats a simultaneous ERET
    fire(1'b1, 32'h80000600, 1'b0, 1'b1, 5'd9, 1'b1, 32'h1, 32'h0, 32'h80001234);
    next_cycle(); check("exc_vs_eret_addr", {27'd0, cp0_waddr}, 32'd14);
    next_cycle(); check("exc_vs_eret_cause", cp0_wdata, 32'h0000_0024);
    idle(4);

    // Inputs wiggling while busy: snapshot must hold
    fire(1'b1, 32'h80000700, 1'b0, 1'b1, 5'd4, 1'b0, 32'h1, 32'h0, 32'h0);
    mem_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      if (k == 3) check("busy_snap_status", cp0_wdata, 32'h0000_0003);
      if (k == 4) check("busy_snap_redirect", {31'd0, redirect_valid}, 32'd1);
      if (k == 5) check("busy_no_back_to_back", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      mem_exc_req = ~mem_exc_req;
      cp0_status  = 32'hFFFF_0000 + 32'(k);
    end
    mem_valid = 1'b0; mem_exc_req = 1'b0;
    idle(6);

    // Reset during W_CAUSE
    fire(1'b1, 32'h80000800, 1'b0, 1'b1, 5'd12, 1'b0, 32'h1, 32'h0, 32'h0);
    next_cycle();
    next_cycle(); check("rst_mid_addr", {27'd0, cp0_waddr}, 32'd13);
    rst = 1'b0;
    #1;
    check("rst_mid_we", {31'd0, cp0_we}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_redirect_pc", redirect_pc, 32'd0);
    idle(2);
    rst = 1'b1;
    idle(4);
    check("rst_after_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
